throw_turn_sched: RTL and testbench

- Game-level sequencer for the two projectile engines, throw_ctl_cat and throw_ctl_dog.
- Runs alternating turns: cat first, then dog.
- Per turn: draws a pseudo-random wind value, charges throw force while the fire button is held, enables the active thrower, and waits for its throw_done.
- Applies damage on a hit, tracks both players' HP, and declares the winner.
- Sits between the debounced button/top FSM and the two throw controllers; its HP outputs feed the HUD.

---
 rtl/throw_turn_sched_if.sv | 32 +++
 rtl/throw_turn_sched.sv | 192 +++++++++++++++++++
 tb/tb_throw_turn_sched.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/throw_turn_sched_if.sv
// Handshake bundle between the turn sequencer, the button/top FSM, the two
// throw controllers and the HUD.
interface throw_turn_sched_if;
  logic       start;
  logic       btn_throw;
  logic       throw_done_cat;
  logic       throw_done_dog;
  logic       hit_by_cat;
  logic       hit_by_dog;
  logic       enable_cat;
  logic       enable_dog;
  logic [9:0] throw_force;
  logic [6:0] wind_force;
  logic       turn;
  logic [6:0] hp_cat;
  logic [6:0] hp_dog;
  logic       charging;
  logic       game_over;
  logic       winner;

  modport master (
    output start, btn_throw, throw_done_cat, throw_done_dog, hit_by_cat, hit_by_dog,
    input  enable_cat, enable_dog, throw_force, wind_force, turn,
    input  hp_cat, hp_dog, charging, game_over, winner
  );

  modport slave (
    input  start, btn_throw, throw_done_cat, throw_done_dog, hit_by_cat, hit_by_dog,
    output enable_cat, enable_dog, throw_force, wind_force, turn,
    output hp_cat, hp_dog, charging, game_over, winner
  );
endinterface

// File: rtl/throw_turn_sched.sv
// Turn sequencer for the cat/dog throwers: wind draw, ping-pong force charge,
// hit/HP bookkeeping and winner. Optional AIM forfeit timer: TURN_TIMEOUT_EN.
module throw_turn_sched #(
  parameter int CHARGE_DIV     = 650000,
  parameter int FORCE_STEP     = 2,
  parameter int FORCE_MAX      = 100,
  parameter int HP_INIT        = 100,
  parameter int DAMAGE         = 20,
  parameter int FLIGHT_TIMEOUT = 130000000,
  parameter int AIM_TIMEOUT    = 650000000
) (
  input logic               clk,
  input logic               rst,
  throw_turn_sched_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_AIM     = 3'd1;
  localparam logic [2:0] S_CHARGE  = 3'd2;
  localparam logic [2:0] S_FLIGHT  = 3'd3;
  localparam logic [2:0] S_RESOLVE = 3'd4;
  localparam logic [2:0] S_SWITCH  = 3'd5;
  localparam logic [2:0] S_OVER    = 3'd6;

  localparam int CW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam int FW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;

  generate
    if (FORCE_MAX > 1023 || FORCE_MAX < 1 || HP_INIT > 127 || HP_INIT < 1 ||
        CHARGE_DIV < 1 || FLIGHT_TIMEOUT < 1 || AIM_TIMEOUT < 1) begin : g_param_chk
      $error("throw_turn_sched: parameter out of range");
    end
  endgenerate

  logic [2:0]    state_reg;
  logic [15:0]   lfsr_reg;
  logic [9:0]    force_reg;
  logic          dir_up_reg;
  logic [6:0]    wind_reg;
  logic          turn_reg;
  logic [6:0]    hp_cat_reg;
  logic [6:0]    hp_dog_reg;
  logic          winner_reg;
  logic          hit_reg;
  logic [CW-1:0] chg_cnt_reg;
  logic [FW-1:0] flight_cnt_reg;
`ifdef TURN_TIMEOUT_EN
  localparam int AW = (AIM_TIMEOUT > 1) ? $clog2(AIM_TIMEOUT) : 1;
  logic [AW-1:0] aim_cnt_reg;
`endif

  function automatic logic [6:0] wind_of(input logic [15:0] l);
    logic [6:0] w;
    w = l[6:0];
    return (w > 7'd100) ? (w - 7'd27) : w;
  endfunction

  logic        lfsr_fb;
  logic        done_act;
  logic        hit_act;
  logic [6:0]  opp_hp;
  logic [6:0]  opp_hp_new;
  logic [10:0] force_up;

  assign lfsr_fb    = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign done_act   = turn_reg ? bus.throw_done_dog : bus.throw_done_cat;
  assign hit_act    = turn_reg ? bus.hit_by_dog : bus.hit_by_cat;
  assign opp_hp     = turn_reg ? hp_cat_reg : hp_dog_reg;
  assign opp_hp_new = !hit_reg ? opp_hp :
                      (opp_hp <= 7'(DAMAGE)) ? 7'd0 : (opp_hp - 7'(DAMAGE));
  assign force_up   = {1'b0, force_reg} + 11'(FORCE_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= 16'hACE1;
      force_reg      <= '0;
      dir_up_reg     <= 1'b1;
      wind_reg       <= 7'd50;
      turn_reg       <= 1'b0;
      hp_cat_reg     <= 7'(HP_INIT);
      hp_dog_reg     <= 7'(HP_INIT);
      winner_reg     <= 1'b0;
      hit_reg        <= 1'b0;
      chg_cnt_reg    <= '0;
      flight_cnt_reg <= '0;
`ifdef TURN_TIMEOUT_EN
      aim_cnt_reg    <= '0;
`endif
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
      case (state_reg)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            hp_cat_reg <= 7'(HP_INIT);
            hp_dog_reg <= 7'(HP_INIT);
            turn_reg   <= 1'b0;
            wind_reg   <= wind_of(lfsr_reg);
            force_reg  <= '0;
            hit_reg    <= 1'b0;
            state_reg  <= S_AIM;
          end
        end
        S_AIM: begin
          force_reg <= '0;
          if (bus.btn_throw) begin
            chg_cnt_reg <= '0;
            dir_up_reg  <= 1'b1;
            state_reg   <= S_CHARGE;
`ifdef TURN_TIMEOUT_EN
            aim_cnt_reg <= '0;
          end else if (aim_cnt_reg == AW'(AIM_TIMEOUT - 1)) begin
            // Forfeit: skip the throw entirely, HP untouched.
            aim_cnt_reg <= '0;
            state_reg   <= S_SWITCH;
          end else begin
            aim_cnt_reg <= aim_cnt_reg + 1'b1;
`endif
          end
        end
        S_CHARGE: begin
          if (!bus.btn_throw) begin
            flight_cnt_reg <= '0;
            hit_reg        <= 1'b0;
            state_reg      <= S_FLIGHT;
          end else if (chg_cnt_reg == CW'(CHARGE_DIV - 1)) begin
            chg_cnt_reg <= '0;
            // Ping-pong between 0 and FORCE_MAX, clamping at both ends.
            if (dir_up_reg) begin
              if (force_up >= 11'(FORCE_MAX)) begin
                force_reg  <= 10'(FORCE_MAX);
                dir_up_reg <= 1'b0;
              end else begin
                force_reg <= force_up[9:0];
              end
            end else begin
              if (force_reg <= 10'(FORCE_STEP)) begin
                force_reg  <= '0;
                dir_up_reg <= 1'b1;
              end else begin
                force_reg <= force_reg - 10'(FORCE_STEP);
              end
            end
          end else begin
            chg_cnt_reg <= chg_cnt_reg + 1'b1;
          end
        end
        S_FLIGHT: begin
          if (hit_act) hit_reg <= 1'b1;
          if (done_act || flight_cnt_reg == FW'(FLIGHT_TIMEOUT - 1)) begin
            flight_cnt_reg <= '0;
            state_reg      <= S_RESOLVE;
          end else begin
            flight_cnt_reg <= flight_cnt_reg + 1'b1;
          end
        end
        S_RESOLVE: begin
          hit_reg <= 1'b0;
          if (turn_reg) hp_cat_reg <= opp_hp_new;
          else          hp_dog_reg <= opp_hp_new;
          if (opp_hp_new == 7'd0) begin
            winner_reg <= turn_reg;
            state_reg  <= S_OVER;
          end else begin
            state_reg <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          // Hold the turn until the active thrower is back at idle.
          if (!done_act) begin
            turn_reg  <= ~turn_reg;
            wind_reg  <= wind_of(lfsr_reg);
            state_reg <= S_AIM;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.enable_cat  = (state_reg == S_FLIGHT) && !turn_reg;
  assign bus.enable_dog  = (state_reg == S_FLIGHT) && turn_reg;
  assign bus.throw_force = force_reg;
  assign bus.wind_force  = wind_reg;
  assign bus.turn        = turn_reg;
  assign bus.hp_cat      = hp_cat_reg;
  assign bus.hp_dog      = hp_dog_reg;
  assign bus.charging    = (state_reg == S_CHARGE);
  assign bus.game_over   = (state_reg == S_OVER);
  assign bus.winner      = winner_reg;

endmodule

// File: tb/tb_throw_turn_sched.sv
// Directed + randomized bench for throw_turn_sched against a turn-level
// reference model (triangle-wave force, HP ledger, LFSR-derived wind).
module tb_throw_turn_sched;

  localparam int CDIV = 4;
  localparam int STEP = 10;
  localparam int FMAX = 100;
  localparam int HPI  = 40;
  localparam int DMG  = 20;
  localparam int FTO  = 40;
  localparam int ATO  = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  throw_turn_sched_if ifc();

  throw_turn_sched #(
    .CHARGE_DIV(CDIV), .FORCE_STEP(STEP), .FORCE_MAX(FMAX), .HP_INIT(HPI),
    .DAMAGE(DMG), .FLIGHT_TIMEOUT(FTO), .AIM_TIMEOUT(ATO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int total = 0;
  int bad = 0;

  // Reference LFSR: last_lfsr is the value the DUT sampled at the latest edge.
  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] last_lfsr = 16'hACE1;
  always @(posedge clk) begin
    last_lfsr <= m_lfsr;
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int m_hp [2];
  int m_turn;
  bit m_over;

  function automatic int wind_exp(input logic [15:0] l);
    int w;
    w = int'(l[6:0]);
    return (w > 100) ? w - 27 : w;
  endfunction

  // Force after n completed charge steps: triangle wave 0..FMAX..0.
  function automatic int tri_force(input int n);
    int p, k;
    p = FMAX / STEP;
    k = n % (2 * p);
    return ((k <= p) ? k : 2 * p - k) * STEP;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hit(input int who, input logic v);
    if (who == 1) ifc.hit_by_dog = v; else ifc.hit_by_cat = v;
  endtask

  task automatic set_done(input int who, input logic v);
    if (who == 1) ifc.throw_done_dog = v; else ifc.throw_done_cat = v;
  endtask

  function automatic logic en_of(input int who);
    return (who == 1) ? ifc.enable_dog : ifc.enable_cat;
  endfunction

  task automatic chk_wind(input string tag);
    chk(tag, 32'(ifc.wind_force), 32'(wind_exp(last_lfsr)));
    chk({tag, "_range"}, 32'(ifc.wind_force <= 7'd100), 32'd1);
  endtask

  task automatic chk_hp(input string tag);
    chk({tag, "_hp_cat"}, 32'(ifc.hp_cat), 32'(m_hp[0]));
    chk({tag, "_hp_dog"}, 32'(ifc.hp_dog), 32'(m_hp[1]));
  endtask

  // One full turn from AIM: charge for ccyc cycles, nh active hits, optional
  // stray hit from the idle player, optional hit coincident with throw_done,
  // or let the flight timer expire instead of signalling throw_done.
  task automatic do_turn(input int ccyc, input int nh, input bit stray,
                         input bit hit_with_done, input bit tmo);
    int t, fc, f, hold;
    bit hit;
    t = m_turn;
    ifc.btn_throw = 1'b1;
    tick();
    chk("charging", 32'(ifc.charging), 32'd1);
    chk("force_start", 32'(ifc.throw_force), 32'd0);
    repeat (ccyc) tick();
    f = tri_force(ccyc / CDIV);
    chk("force_charge", 32'(ifc.throw_force), 32'(f));
    ifc.btn_throw = 1'b0;
    tick();
    fc = 0;
    chk("force_latch", 32'(ifc.throw_force), 32'(f));
    chk("enable_active", 32'(en_of(t)), 32'd1);
    chk("enable_idle", 32'(en_of(1 - t)), 32'd0);
    chk("charging_off", 32'(ifc.charging), 32'd0);
    ifc.start = 1'b1;
    tick(); fc++;
    ifc.start = 1'b0;
    chk("start_ignored", 32'(en_of(t)), 32'd1);
    for (int i = 0; i < nh; i++) begin
      set_hit(t, 1'b1); tick(); fc++;
      set_hit(t, 1'b0); tick(); fc++;
    end
    if (stray) begin
      set_hit(1 - t, 1'b1); tick(); fc++;
      set_hit(1 - t, 1'b0);
    end
    if (tmo) begin
      while (en_of(t) && fc < FTO + 5) begin
        tick(); fc++;
      end
      chk("flight_timeout", 32'((!en_of(t)) && fc >= FTO - 1 && fc <= FTO + 1), 32'd1);
    end else begin
      set_done(t, 1'b1);
      if (hit_with_done) set_hit(t, 1'b1);
      tick();
      set_hit(t, 1'b0);
      chk("resolve_enable", 32'(en_of(t)), 32'd0);
    end
    tick();
    hit = (nh > 0) || (hit_with_done && !tmo);
    if (hit) m_hp[1 - t] = (m_hp[1 - t] <= DMG) ? 0 : m_hp[1 - t] - DMG;
    chk_hp("resolve");
    if (m_hp[1 - t] == 0) begin
      m_over = 1'b1;
      set_done(t, 1'b0);
      chk("game_over", 32'(ifc.game_over), 32'd1);
      chk("winner", 32'(ifc.winner), 32'(t));
      chk("over_enables", 32'({ifc.enable_cat, ifc.enable_dog}), 32'd0);
      return;
    end
    if (!tmo) begin
      hold = int'($urandom_range(1, 3));
      for (int i = 0; i < hold; i++) begin
        chk("switch_hold_turn", 32'(ifc.turn), 32'(t));
        tick();
      end
      chk("switch_hold_turn", 32'(ifc.turn), 32'(t));
      set_done(t, 1'b0);
    end
    tick();
    m_turn = 1 - t;
    chk("turn_toggle", 32'(ifc.turn), 32'(m_turn));
    chk_wind("wind_redraw");
    chk("no_over", 32'(ifc.game_over), 32'd0);
  endtask

  task automatic start_game(input string tag);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    m_hp[0] = HPI; m_hp[1] = HPI; m_turn = 0; m_over = 1'b0;
    chk_hp(tag);
    chk({tag, "_turn"}, 32'(ifc.turn), 32'd0);
    chk({tag, "_over"}, 32'(ifc.game_over), 32'd0);
    chk_wind({tag, "_wind"});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, 32'({ifc.enable_cat, ifc.enable_dog}), 32'd0);
    chk({tag, "_force"}, 32'(ifc.throw_force), 32'd0);
    chk({tag, "_wind"}, 32'(ifc.wind_force), 32'd50);
    chk({tag, "_turn"}, 32'(ifc.turn), 32'd0);
    chk({tag, "_hp_cat"}, 32'(ifc.hp_cat), 32'(HPI));
    chk({tag, "_hp_dog"}, 32'(ifc.hp_dog), 32'(HPI));
    chk({tag, "_flags"}, 32'({ifc.charging, ifc.game_over, ifc.winner}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int turns;
    ifc.start = 1'b0; ifc.btn_throw = 1'b0;
    ifc.throw_done_cat = 1'b0; ifc.throw_done_dog = 1'b0;
    ifc.hit_by_cat = 1'b0; ifc.hit_by_dog = 1'b0;
    m_hp[0] = HPI; m_hp[1] = HPI; m_turn = 0; m_over = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");
    repeat (int'($urandom_range(0, 7))) tick();

    // Scripted game: cat multi-hit + stray, dog no-hit, cat timeout,
    // dog hit, cat miss, dog hit together with throw_done -> dog wins.
    start_game("start1");
    do_turn(100, 3, 1'b1, 1'b0, 1'b0);
    do_turn(80, 0, 1'b1, 1'b0, 1'b0);
    do_turn(int'($urandom_range(1, 120)), 0, 1'b0, 1'b0, 1'b1);
    do_turn(int'($urandom_range(1, 120)), 1, 1'b0, 1'b0, 1'b0);
    do_turn(int'($urandom_range(1, 120)), 0, 1'b0, 1'b0, 1'b0);
    do_turn(int'($urandom_range(1, 120)), 0, 1'b0, 1'b1, 1'b0);
    chk("scripted_game_ended", 32'(m_over), 32'd1);

    // OVER ignores fire/hit inputs and holds HP and winner.
    ifc.btn_throw = 1'b1; ifc.hit_by_cat = 1'b1; ifc.hit_by_dog = 1'b1;
    repeat (3) tick();
    ifc.btn_throw = 1'b0; ifc.hit_by_cat = 1'b0; ifc.hit_by_dog = 1'b0;
    chk("over_hold", 32'(ifc.game_over), 32'd1);
    chk("over_winner_hold", 32'(ifc.winner), 32'd1);
    chk_hp("over_hold");

    // Randomized game.
    start_game("start2");
    turns = 0;
    while (!m_over && turns < 8) begin
      do_turn(int'($urandom_range(1, 120)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
      turns++;
    end
    if (m_over) start_game("start3");

    // Reset in the middle of a flight.
    ifc.btn_throw = 1'b1;
    tick();
    repeat (int'($urandom_range(1, 40))) tick();
    ifc.btn_throw = 1'b0;
    tick();
    chk("pre_rst_enable", 32'(ifc.enable_cat), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0;
    tick();
    chk_reset("post_rst");

`ifdef TURN_TIMEOUT_EN
    begin
      int wc;
      start_game("start_tmo");
      wc = 0;
      while (ifc.turn == 1'b0 && wc < 2 * ATO + 10) begin
        tick(); wc++;
      end
      chk("aim_forfeit", 32'(ifc.turn == 1'b1 && wc >= ATO && wc <= ATO + 3), 32'd1);
      chk_hp("aim_forfeit");
      chk("aim_forfeit_over", 32'(ifc.game_over), 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
